// File: rtl/univ_reg_pkg.sv
// univ_reg_pkg: mode encodings shared by the universal register and its users
package univ_reg_pkg;
  localparam int MODE_W = 3;
  localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'b001;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'b011;
  localparam logic [MODE_W-1:0] MODE_ROTL = 3'b100;
  localparam logic [MODE_W-1:0] MODE_ROTR = 3'b101;
  localparam logic [MODE_W-1:0] MODE_INC  = 3'b110;
  localparam logic [MODE_W-1:0] MODE_DEC  = 3'b111;
endpackage

// File: rtl/univ_reg_cell.sv
// univ_reg_cell: one storage bit with reset, clear, preset, enable priority
module univ_reg_cell (
  input  logic clk,
  input  logic reset,
  input  logic reset_val,
  input  logic clear,
  input  logic preset,
  input  logic en,
  input  logic nxt,
  output logic q,
  output logic qbar
);
  logic q_q;
  // reset beats clear beats preset beats the word operation
  always_ff @(posedge clk)
    q_q <= !reset ? reset_val : clear ? 1'b0 : preset ? 1'b1 : en ? nxt : q_q;
  assign q    = q_q;
  assign qbar = ~q_q;
endmodule

// File: rtl/univ_reg.sv
// univ_reg: N-bit register with load, shift, rotate, count, per-bit masks
module univ_reg
  import univ_reg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  d,
  input  logic              sin_l,
  input  logic              sin_r,
  input  logic [WIDTH-1:0]  preset,
  input  logic [WIDTH-1:0]  clear,
  output logic [WIDTH-1:0]  q,
  output logic [WIDTH-1:0]  qbar,
  output logic              sout,
  output logic              wrap
);
  logic [WIDTH-1:0] nxt_d;
  logic             wrap_d, wrap_q;
  // word result from the pre-edge value; masks are applied per cell afterwards
  always_comb begin
    nxt_d = q;
    case (mode)
      MODE_LOAD: nxt_d = d;
      MODE_SHL:  nxt_d = {q[WIDTH-2:0], sin_l};
      MODE_SHR:  nxt_d = {sin_r, q[WIDTH-1:1]};
      MODE_ROTL: nxt_d = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROTR: nxt_d = {q[0], q[WIDTH-1:1]};
      MODE_INC:  nxt_d = q + WIDTH'(1);
      MODE_DEC:  nxt_d = q - WIDTH'(1);
      default:   nxt_d = q;
    endcase
  end
  assign wrap_d = en && ((mode == MODE_INC && &q) || (mode == MODE_DEC && ~|q));
  // wrap pulses for the cycle following a counter rollover
  always_ff @(posedge clk)
    wrap_q <= reset ? wrap_d : 1'b0;
  assign wrap = wrap_q;
  assign sout = (mode == MODE_SHR) ? q[0] : q[WIDTH-1];
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    univ_reg_cell u_cell (
      .clk       (clk),
      .reset     (reset),
      .reset_val (RESET_VAL[i]),
      .clear     (clear[i]),
      .preset    (preset[i]),
      .en        (en),
      .nxt       (nxt_d[i]),
      .q         (q[i]),
      .qbar      (qbar[i])
    );
  end
endmodule

// File: doc/univ_reg.md
Name: univ_reg

Overview:
- Parametrised N-bit universal register, the multi-bit successor to the single preset/clear flip-flop.
- Per-bit synchronous preset/clear masks override a mode-selected word operation: hold, load, shift, rotate, increment, decrement.
- Provides true and complement outputs, serial out, and a registered wrap flag.
- Used as the general storage/shift/count element in datapaths and test structures.

Parameters:
- WIDTH, 8, register width in bits (≥2).
- RESET_VAL, {WIDTH{1'b0}}, value of q after reset.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low reset.
- en  in  1  enable for mode operation; preset/clear act regardless of en.
- mode  in  3  operation select (encodings in package).
- d  in  WIDTH  parallel load data.
- sin_l  in  1  serial input shifted into bit 0 on SHL.
- sin_r  in  1  serial input shifted into bit WIDTH-1 on SHR.
- preset  in  WIDTH  per-bit synchronous set mask.
- clear  in  WIDTH  per-bit synchronous clear mask.
- q  out  WIDTH  register value.
- qbar  out  WIDTH  always exactly ~q.
- sout  out  1  SHL: q[WIDTH-1]; SHR: q[0]; otherwise q[WIDTH-1]. Combinational from q and mode.
- wrap  out  1  registered; high for one cycle after an INC/DEC wrap.

Behaviour:
- Mode encodings:
  - 000 HOLD
  - 001 LOAD: q ← d
  - 010 SHL: q ← {q[W-2:0], sin_l}
  - 011 SHR: q ← {sin_r, q[W-1:1]}
  - 100 ROTL: q ← {q[W-2:0], q[W-1]}
  - 101 ROTR: q ← {q[0], q[W-1:1]}
  - 110 INC: q ← q+1, modulo 2^W
  - 111 DEC: q ← q-1, modulo 2^W
- Per-edge priority, evaluated per bit:
  1. reset==0 → q=RESET_VAL, wrap=0.
  2. clear[i]=1 → q[i]=0.
  3. preset[i]=1 → q[i]=1.
  4. en=1 → q[i] = bit i of the mode result.
  5. Otherwise hold.
- clear and preset both set on a bit: clear wins.
- The mode result is computed from the pre-edge q; masked bits are then overridden. A masked bit does not block a carry/shift into its neighbours.
- Latency: one cycle from inputs to q/qbar. No combinational input→q path.
- wrap:
  - Next value is 1 iff reset=1 and en=1 and either (mode=INC and q=all-ones) or (mode=DEC and q=0).
  - Evaluated on the pre-edge q, before mask override.
  - Otherwise next value is 0.
- qbar is derived from q, never stored separately; qbar===~q on every cycle, including reset.
- Reset asserted mid-operation (any mode, any masks): after that edge q=RESET_VAL and wrap=0. The first post-reset operation acts on RESET_VAL.
- Unknown/X on mode with en=1 is a bench error. Behaviour is not specified.

Decomposition:
- Package univ_reg_pkg holds:
  - mode localparams: MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR, MODE_ROTL, MODE_ROTR, MODE_INC, MODE_DEC
  - MODE_W=3
- Sub-module univ_reg_cell, one per bit (generate loop).
  - Inputs: clk, reset, reset_val bit, clear, preset, en, nxt.
  - Outputs: q, qbar.
  - Implements priority items 1–5.
- Word-level next-value mux and wrap logic live in univ_reg.

Test Plan (WIDTH=8, RESET_VAL=8'h00):
- Reset: hold reset=0 for 3 cycles with en=1, mode=INC, preset=8'hFF → q=8'h00, qbar=8'hFF, wrap=0 on every cycle.
- Load/hold: LOAD d=8'hA5, then HOLD for 4 cycles → q=8'hA5, qbar=8'h5A throughout. With en=0 and mode=LOAD, d=8'h3C → q stays 8'hA5.
- Shift/rotate:
  - From 8'h81: SHL sin_l=0 → 8'h02, sout=0.
  - From 8'h81: ROTR → 8'hC0.
  - From 8'h81: SHR sin_r=1 → 8'hC0, sout=1 before the edge.
- Count wrap:
  - LOAD 8'hFE, INC ×2 → 8'hFF then 8'h00; wrap=1 in the cycle after reaching 8'h00 only.
  - DEC from 8'h00 → 8'hFF with wrap pulse.
- Mask priority: q=8'h0F, mode=LOAD, d=8'hF0, en=1, clear=8'h01, preset=8'h81 → q=8'hF0. Bit0 clear wins over preset; bit7 preset agrees with d.
- Mid-op reset: INC running at 8'h10, assert reset=0 for one edge → q=8'h00. Next INC gives 8'h01, wrap=0.
